// File: rtl/axi_pkg.sv
// Shared AXI3 constants and the FSM state type for the single-beat SRAM slave.
package axi_pkg;

    localparam int AXI_ID_W   = 4;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        RD_ACC,
        RD_WAIT,
        RD_RESP,
        WR_DATA,
        WR_WAIT,
        WR_RESP
    } sram_slave_state_e;

    // Counter preload so that a delay of D spends exactly D cycles in the wait state.
    function automatic logic [7:0] delay_preload(input int delay);
        if (delay > 0) begin
            return 8'(delay - 1);
        end
        return 8'd0;
    endfunction

endpackage

// File: rtl/sram_1rw_bw.sv
// Single-port word SRAM, one-cycle registered read, independent byte-lane write enables.
module sram_1rw_bw
    import axi_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic                  aclk,
    input  logic                  re,
    input  logic [AXI_STRB_W-1:0] we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [AXI_DATA_W-1:0] wdata,
    output logic [AXI_DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    // One narrow array per byte lane keeps each lane a plain write-enable RAM.
    generate
        for (genvar gi = 0; gi < AXI_STRB_W; gi++) begin : g_lane
            logic [7:0] lane_mem [0:DEPTH-1];
            logic [7:0] lane_rdata_reg;

            always_ff @(posedge aclk) begin
                if (we[gi]) begin
                    lane_mem[addr] <= wdata[gi*8 +: 8];
                end
                if (re) begin
                    lane_rdata_reg <= lane_mem[addr];
                end
            end

            assign rdata[gi*8 +: 8] = lane_rdata_reg;
        end
    endgenerate

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 single-beat slave in front of a word SRAM with programmable read/write response delays.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int READ_DELAY  = 0,
    parameter int WRITE_DELAY = 0
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [AXI_ID_W-1:0]   arid,
    input  logic [31:0]           araddr,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic [1:0]            arlock,
    input  logic [3:0]            arcache,
    input  logic [2:0]            arprot,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [AXI_ID_W-1:0]   rid,
    output logic [AXI_DATA_W-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic [AXI_ID_W-1:0]   awid,
    input  logic [31:0]           awaddr,
    input  logic [7:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic [1:0]            awlock,
    input  logic [3:0]            awcache,
    input  logic [2:0]            awprot,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [AXI_ID_W-1:0]   wid,
    input  logic [AXI_DATA_W-1:0] wdata,
    input  logic [AXI_STRB_W-1:0] wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [AXI_ID_W-1:0]   bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready
);

    generate
        if (READ_DELAY < 0 || READ_DELAY > 255 || WRITE_DELAY < 0 || WRITE_DELAY > 255) begin : g_bad_delay
            $error("axi_sram_slave: READ_DELAY/WRITE_DELAY must be within 0..255");
        end
    endgenerate

    localparam logic [7:0] RD_PRELOAD = delay_preload(READ_DELAY);
    localparam logic [7:0] WR_PRELOAD = delay_preload(WRITE_DELAY);

    sram_slave_state_e     state_reg;
    logic [ADDR_W-1:0]     addr_reg;
    logic [AXI_ID_W-1:0]   rid_reg;
    logic [AXI_ID_W-1:0]   bid_reg;
    logic [7:0]            cnt_reg;
    logic [AXI_DATA_W-1:0] sram_rdata;
    logic                  sram_re;
    logic [AXI_STRB_W-1:0] sram_we;

    // Burst/cache/protection attributes and the byte offset carry no meaning for single-word access.
    logic unused_inputs;
    assign unused_inputs = ^{arlen, arsize, arburst, arlock, arcache, arprot, araddr[1:0],
                             awlen, awsize, awburst, awlock, awcache, awprot, awaddr[1:0],
                             araddr[31:ADDR_W+2], awaddr[31:ADDR_W+2], wid, wlast};

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_reg <= INIT;
            addr_reg  <= '0;
            rid_reg   <= '0;
            bid_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                INIT: state_reg <= IDLE;
                IDLE: begin
                    // Write wins a simultaneous request; arready is already masked by awvalid.
                    if (awvalid) begin
                        bid_reg   <= awid;
                        addr_reg  <= awaddr[ADDR_W+1:2];
                        state_reg <= WR_DATA;
                    end else if (arvalid) begin
                        rid_reg   <= arid;
                        addr_reg  <= araddr[ADDR_W+1:2];
                        state_reg <= RD_ACC;
                    end
                end
                RD_ACC: begin
                    if (READ_DELAY > 0) begin
                        cnt_reg   <= RD_PRELOAD;
                        state_reg <= RD_WAIT;
                    end else begin
                        state_reg <= RD_RESP;
                    end
                end
                RD_WAIT: begin
                    if (cnt_reg == 8'd0) begin
                        state_reg <= RD_RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 8'd1;
                    end
                end
                RD_RESP: begin
                    if (rready) begin
                        state_reg <= IDLE;
                    end
                end
                WR_DATA: begin
                    if (wvalid) begin
                        if (WRITE_DELAY > 0) begin
                            cnt_reg   <= WR_PRELOAD;
                            state_reg <= WR_WAIT;
                        end else begin
                            state_reg <= WR_RESP;
                        end
                    end
                end
                WR_WAIT: begin
                    if (cnt_reg == 8'd0) begin
                        state_reg <= WR_RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 8'd1;
                    end
                end
                WR_RESP: begin
                    if (bready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= INIT;
            endcase
        end
    end

    assign sram_re = (state_reg == RD_ACC);
    assign sram_we = (state_reg == WR_DATA && wvalid) ? wstrb : '0;

    sram_1rw_bw #(
        .ADDR_W (ADDR_W)
    ) u_sram (
        .aclk   (aclk),
        .re     (sram_re),
        .we     (sram_we),
        .addr   (addr_reg),
        .wdata  (wdata),
        .rdata  (sram_rdata)
    );

    // The SRAM output register only reloads in RD_ACC, so it holds steady across the whole response.
    assign awready = (state_reg == IDLE);
    assign arready = (state_reg == IDLE) && !awvalid;
    assign wready  = (state_reg == WR_DATA);
    assign rvalid  = (state_reg == RD_RESP);
    assign rlast   = rvalid;
    assign rdata   = rvalid ? sram_rdata : '0;
    assign rid     = rid_reg;
    assign rresp   = AXI_RESP_OKAY;
    assign bvalid  = (state_reg == WR_RESP);
    assign bid     = bid_reg;
    assign bresp   = AXI_RESP_OKAY;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Bench for axi_sram_slave: a zero-delay and a delayed instance checked against a word-array memory model.
module tb_axi_sram_slave;

    localparam int AW  = 8;
    localparam int RD1 = 3;
    localparam int WD1 = 2;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic [1:0][3:0]  arid, awid;
    logic [1:0][31:0] araddr, awaddr, wdata;
    logic [1:0][3:0]  wstrb;
    logic [1:0]       arvalid, rready, awvalid, wvalid, bready;

    wire [1:0]        arready, rvalid, rlast, awready, wready, bvalid;
    wire [1:0][3:0]   rid, bid;
    wire [1:0][31:0]  rdata;
    wire [1:0][1:0]   rresp, bresp;

    logic [7:0] len_c   = 8'd0;
    logic [2:0] size_c  = 3'd2;
    logic [1:0] burst_c = 2'b01;
    logic [1:0] lock_c  = 2'b00;
    logic [3:0] cache_c = 4'd0;
    logic [2:0] prot_c  = 3'd0;
    logic [3:0] wid_c   = 4'd0;
    logic       wlast_c = 1'b1;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            axi_sram_slave #(
                .ADDR_W      (AW),
                .READ_DELAY  (gi == 1 ? RD1 : 0),
                .WRITE_DELAY (gi == 1 ? WD1 : 0)
            ) u_dut (
                .aclk    (aclk),
                .aresetn (aresetn),
                .arid    (arid[gi]),
                .araddr  (araddr[gi]),
                .arlen   (len_c),
                .arsize  (size_c),
                .arburst (burst_c),
                .arlock  (lock_c),
                .arcache (cache_c),
                .arprot  (prot_c),
                .arvalid (arvalid[gi]),
                .arready (arready[gi]),
                .rid     (rid[gi]),
                .rdata   (rdata[gi]),
                .rresp   (rresp[gi]),
                .rlast   (rlast[gi]),
                .rvalid  (rvalid[gi]),
                .rready  (rready[gi]),
                .awid    (awid[gi]),
                .awaddr  (awaddr[gi]),
                .awlen   (len_c),
                .awsize  (size_c),
                .awburst (burst_c),
                .awlock  (lock_c),
                .awcache (cache_c),
                .awprot  (prot_c),
                .awvalid (awvalid[gi]),
                .awready (awready[gi]),
                .wid     (wid_c),
                .wdata   (wdata[gi]),
                .wstrb   (wstrb[gi]),
                .wlast   (wlast_c),
                .wvalid  (wvalid[gi]),
                .wready  (wready[gi]),
                .bid     (bid[gi]),
                .bresp   (bresp[gi]),
                .bvalid  (bvalid[gi]),
                .bready  (bready[gi])
            );
        end
    endgenerate

    int rd_dly [2];
    int wr_dly [2];
    logic [31:0] model_mem [2][256];
    bit          model_ok  [2][256];
    int total = 0;
    int bad   = 0;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

    function automatic int widx(input logic [31:0] addr);
        return int'(addr[AW+1:2]);
    endfunction

    task automatic do_write(input int k, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [3:0] id, input int hold, input bit early_w);
        int guard;
        int lat;
        bit stray;
        awaddr[k] = addr; awid[k] = id; awvalid[k] = 1'b1;
        wdata[k] = data; wstrb[k] = strb; wvalid[k] = early_w;
        guard = 0;
        while (!awready[k] && guard < 20) begin tick(); guard++; end
        total++;
        if (awready[k] !== 1'b1) begin bad++; $display("FAIL wr_awready k=%0d got=%b want=1", k, awready[k]); end
        tick();
        awvalid[k] = 1'b0;
        wvalid[k] = 1'b1;
        guard = 0;
        while (!wready[k] && guard < 20) begin tick(); guard++; end
        total++;
        if (wready[k] !== 1'b1) begin bad++; $display("FAIL wr_wready k=%0d got=%b want=1", k, wready[k]); end
        tick();
        wvalid[k] = 1'b0;
        lat = 1;
        stray = 1'b0;
        while (!bvalid[k] && lat < 300) begin
            if (arready[k] || awready[k] || wready[k]) stray = 1'b1;
            tick();
            lat++;
        end
        total++;
        if (lat != 1 + wr_dly[k]) begin bad++; $display("FAIL wr_latency k=%0d got=%0d want=%0d", k, lat, 1 + wr_dly[k]); end
        total++;
        if (stray) begin bad++; $display("FAIL wr_ready_in_wait k=%0d got=1 want=0", k); end
        total++;
        if (bid[k] !== id || bresp[k] !== 2'b00) begin
            bad++; $display("FAIL wr_bid_bresp k=%0d got=%h/%b want=%h/00", k, bid[k], bresp[k], id);
        end
        for (int h = 0; h < hold; h++) begin
            tick();
            total++;
            if (bvalid[k] !== 1'b1 || bid[k] !== id || awready[k] !== 1'b0 || arready[k] !== 1'b0) begin
                bad++; $display("FAIL wr_hold k=%0d got bvalid=%b bid=%h awready=%b want 1/%h/0", k, bvalid[k], bid[k], awready[k], id);
            end
        end
        bready[k] = 1'b1;
        tick();
        bready[k] = 1'b0;
        total++;
        if (bvalid[k] !== 1'b0 || awready[k] !== 1'b1) begin
            bad++; $display("FAIL wr_done k=%0d got bvalid=%b awready=%b want 0/1", k, bvalid[k], awready[k]);
        end
        model_mem[k][widx(addr)] = merge(model_ok[k][widx(addr)] ? model_mem[k][widx(addr)] : 32'h0, data, strb);
        if (strb == 4'hF) model_ok[k][widx(addr)] = 1'b1;
        $display("wr k=%0d addr=%h data=%h strb=%h id=%h lat=%0d hold=%0d", k, addr, data, strb, id, lat, hold);
    endtask

    task automatic do_read(input int k, input logic [31:0] addr, input logic [3:0] id, input int hold);
        int guard;
        int lat;
        bit stray;
        logic [31:0] exp_d;
        exp_d = model_mem[k][widx(addr)];
        araddr[k] = addr; arid[k] = id; arvalid[k] = 1'b1;
        guard = 0;
        while (!arready[k] && guard < 20) begin tick(); guard++; end
        total++;
        if (arready[k] !== 1'b1) begin bad++; $display("FAIL rd_arready k=%0d got=%b want=1", k, arready[k]); end
        tick();
        arvalid[k] = 1'b0;
        lat = 1;
        stray = 1'b0;
        while (!rvalid[k] && lat < 300) begin
            if (arready[k] || awready[k] || wready[k]) stray = 1'b1;
            tick();
            lat++;
        end
        total++;
        if (lat != 2 + rd_dly[k]) begin bad++; $display("FAIL rd_latency k=%0d got=%0d want=%0d", k, lat, 2 + rd_dly[k]); end
        total++;
        if (stray) begin bad++; $display("FAIL rd_ready_in_wait k=%0d got=1 want=0", k); end
        total++;
        if (rdata[k] !== exp_d) begin bad++; $display("FAIL rd_data k=%0d addr=%h got=%h want=%h", k, addr, rdata[k], exp_d); end
        total++;
        if (rid[k] !== id || rresp[k] !== 2'b00 || rlast[k] !== 1'b1) begin
            bad++; $display("FAIL rd_attr k=%0d got rid=%h rresp=%b rlast=%b want %h/00/1", k, rid[k], rresp[k], rlast[k], id);
        end
        for (int h = 0; h < hold; h++) begin
            tick();
            total++;
            if (rvalid[k] !== 1'b1 || rdata[k] !== exp_d || rid[k] !== id || arready[k] !== 1'b0) begin
                bad++; $display("FAIL rd_hold k=%0d got rvalid=%b rdata=%h rid=%h want 1/%h/%h", k, rvalid[k], rdata[k], rid[k], exp_d, id);
            end
        end
        rready[k] = 1'b1;
        tick();
        rready[k] = 1'b0;
        total++;
        if (rvalid[k] !== 1'b0 || arready[k] !== 1'b1) begin
            bad++; $display("FAIL rd_done k=%0d got rvalid=%b arready=%b want 0/1", k, rvalid[k], arready[k]);
        end
        $display("rd k=%0d addr=%h data=%h id=%h lat=%0d hold=%0d", k, addr, rdata[k], id, lat, hold);
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        arvalid = 2'b11;
        awvalid = 2'b11;
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                total++;
                if ({arready[k], awready[k], wready[k], rvalid[k], bvalid[k], rlast[k]} !== 6'b0 ||
                    rid[k] !== 4'h0 || bid[k] !== 4'h0 || rdata[k] !== 32'h0) begin
                    bad++; $display("FAIL reset_outputs k=%0d cyc=%0d got rdy=%b%b%b vld=%b%b rid=%h bid=%h rdata=%h want all 0",
                                    k, c, arready[k], awready[k], wready[k], rvalid[k], bvalid[k], rid[k], bid[k], rdata[k]);
                end
            end
        end
        arvalid = 2'b00;
        awvalid = 2'b00;
        aresetn = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (awready[k] !== 1'b1 || arready[k] !== 1'b1) begin
                bad++; $display("FAIL reset_first_ready k=%0d got aw=%b ar=%b want 1/1", k, awready[k], arready[k]);
            end
        end
        $display("reset released");
    endtask

    task automatic test_write_read();
        for (int k = 0; k < 2; k++) begin
            do_write(k, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 4'h1, 0, 1'b1);
            do_read(k, 32'h0000_0010, 4'h0, 0);
        end
    endtask

    task automatic test_strobes();
        for (int k = 0; k < 2; k++) begin
            do_write(k, 32'h0000_0024, 32'h11223344, 4'hF, 4'h2, 0, 1'b0);
            do_write(k, 32'h0000_0024, 32'hAABBCCDD, 4'b0101, 4'h3, 0, 1'b1);
            do_read(k, 32'h0000_0024, 4'h4, 0);
            do_write(k, 32'h0000_0024, 32'h55667788, 4'b0000, 4'h5, 0, 1'b1);
            do_read(k, 32'h0000_0024, 4'h6, 0);
        end
    endtask

    task automatic test_priority();
        int guard;
        logic [31:0] nd;
        for (int k = 0; k < 2; k++) begin
            nd = $urandom;
            do_write(k, 32'h0000_0030, 32'h0, 4'hF, 4'h0, 0, 1'b1);
            awaddr[k] = 32'h0000_0030; awid[k] = 4'h5; wdata[k] = nd; wstrb[k] = 4'hF;
            araddr[k] = 32'h0000_0030; arid[k] = 4'h3;
            awvalid[k] = 1'b1; arvalid[k] = 1'b1;
            #1;
            total++;
            if (awready[k] !== 1'b1 || arready[k] !== 1'b0) begin
                bad++; $display("FAIL prio_ready k=%0d got aw=%b ar=%b want 1/0", k, awready[k], arready[k]);
            end
            tick();
            awvalid[k] = 1'b0;
            wvalid[k] = 1'b1;
            guard = 0;
            while (!wready[k] && guard < 20) begin tick(); guard++; end
            tick();
            wvalid[k] = 1'b0;
            guard = 0;
            while (!bvalid[k] && guard < 300) begin tick(); guard++; end
            total++;
            if (bvalid[k] !== 1'b1 || bid[k] !== 4'h5 || arready[k] !== 1'b0) begin
                bad++; $display("FAIL prio_bresp k=%0d got bvalid=%b bid=%h arready=%b want 1/5/0", k, bvalid[k], bid[k], arready[k]);
            end
            bready[k] = 1'b1;
            tick();
            bready[k] = 1'b0;
            model_mem[k][widx(32'h30)] = nd;
            total++;
            if (arready[k] !== 1'b1) begin bad++; $display("FAIL prio_ar_after_b k=%0d got=%b want=1", k, arready[k]); end
            tick();
            arvalid[k] = 1'b0;
            guard = 0;
            while (!rvalid[k] && guard < 300) begin tick(); guard++; end
            total++;
            if (rvalid[k] !== 1'b1 || rdata[k] !== nd || rid[k] !== 4'h3) begin
                bad++; $display("FAIL prio_read k=%0d got rvalid=%b rdata=%h rid=%h want 1/%h/3", k, rvalid[k], rdata[k], rid[k], nd);
            end
            rready[k] = 1'b1;
            tick();
            rready[k] = 1'b0;
            $display("prio k=%0d write then read data=%h", k, nd);
        end
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 2; k++) begin
            do_write(k, 32'h0000_0040, $urandom, 4'hF, 4'h9, 5, 1'b1);
            do_read(k, 32'h0000_0040, 4'hA, 5);
        end
    endtask

    task automatic test_random();
        int w;
        logic [31:0] a;
        logic [3:0] s;
        for (int n = 0; n < 50; n++) begin
            for (int k = 0; k < 2; k++) begin
                w = $urandom_range(0, 31);
                // Upper bits above the word field alias; byte offset is ignored.
                a = ($urandom & 32'hFFFF_FC00) | (32'(w) << 2) | ($urandom & 32'h3);
                if (model_ok[k][w] && $urandom_range(0, 1) == 1) begin
                    do_read(k, a, 4'($urandom), $urandom_range(0, 3));
                end else begin
                    s = model_ok[k][w] ? 4'($urandom) : 4'hF;
                    do_write(k, a, $urandom, s, 4'($urandom), $urandom_range(0, 3), 1'($urandom));
                end
            end
        end
    endtask

    task automatic test_reset_midread();
        int guard;
        bit seen;
        do_write(1, 32'h0000_0050, 32'hCAFEF00D, 4'hF, 4'h7, 0, 1'b1);
        araddr[1] = 32'h0000_0050; arid[1] = 4'hB; arvalid[1] = 1'b1;
        guard = 0;
        while (!arready[1] && guard < 20) begin tick(); guard++; end
        tick();
        arvalid[1] = 1'b0;
        tick();
        tick();
        aresetn = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (rvalid[1] || rvalid[0]) seen = 1'b1;
            tick();
        end
        total++;
        if (seen) begin bad++; $display("FAIL rst_midread_rvalid got=1 want=0"); end
        total++;
        if (arready[1] !== 1'b1 || rid[1] !== 4'h0) begin
            bad++; $display("FAIL rst_midread_idle got arready=%b rid=%h want 1/0", arready[1], rid[1]);
        end
        $display("reset during read wait applied");
        do_read(1, 32'h0000_0050, 4'hC, 0);
        do_read(0, 32'h0000_0010, 4'hD, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rd_dly[0] = 0;   wr_dly[0] = 0;
        rd_dly[1] = RD1; wr_dly[1] = WD1;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 256; i++) begin
                model_mem[k][i] = 32'h0;
                model_ok[k][i]  = 1'b0;
            end
        end
        arid = '0; araddr = '0; awid = '0; awaddr = '0; wdata = '0; wstrb = '0;
        arvalid = '0; rready = '0; awvalid = '0; wvalid = '0; bready = '0;
        test_reset();
        test_write_read();
        test_strobes();
        test_priority();
        test_backpressure();
        test_random();
        test_reset_midread();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
